// File: rtl/addsub_sequencer.sv
// addsub_sequencer: drives a register-file port to perform one add/subtract
// request at a time (read two sources, compute, write back, report flags).
module addsub_sequencer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter bit PROTECT_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_rs_a,
    input  logic [ADDR_W-1:0] req_rs_b,
    input  logic [ADDR_W-1:0] req_rd,
    output logic [ADDR_W-1:0] srcRegA,
    output logic [ADDR_W-1:0] srcRegB,
    input  logic [DATA_W-1:0] outBusA,
    input  logic [DATA_W-1:0] outBusB,
    output logic              regWrite,
    output logic [ADDR_W-1:0] destReg,
    output logic [DATA_W-1:0] writeData,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_v,
    output logic              flag_z
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t            r_state, w_next;
    logic              r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_op_a, r_op_b;
    logic [DATA_W-1:0] w_b, w_res;
    logic [DATA_W:0]   w_sum;
    logic              w_v;

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        regWrite  = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = READ;
            end
            READ: w_next = EXEC;
            EXEC: w_next = WRITE;
            WRITE: begin
                w_next   = IDLE;
                done     = 1'b1;
                regWrite = !(PROTECT_R0 && destReg == '0);
            end
        endcase
    end

    // Subtract is A + ~B + 1, so carry out means "no borrow".
    assign w_b   = r_op ? ~r_op_b : r_op_b;
    assign w_sum = {1'b0, r_op_a} + {1'b0, w_b} + (DATA_W+1)'(r_op);
    assign w_res = w_sum[DATA_W-1:0];
    assign w_v   = (r_op_a[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != r_op_a[DATA_W-1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= 1'b0;
            r_rd      <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            srcRegA   <= '0;
            srcRegB   <= '0;
            destReg   <= '0;
            writeData <= '0;
            result    <= '0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_z    <= 1'b0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_op    <= req_op;
                r_rd    <= req_rd;
                srcRegA <= req_rs_a;
                srcRegB <= req_rs_b;
            end
            if (r_state == READ) begin
                r_op_a <= outBusA;
                r_op_b <= outBusB;
            end
            if (r_state == EXEC) begin
                destReg   <= r_rd;
                writeData <= w_res;
                result    <= w_res;
                flag_c    <= w_sum[DATA_W];
                flag_v    <= w_v;
                flag_z    <= (w_res == '0);
            end
        end
    end
endmodule

// File: tb/tb_addsub_sequencer.sv
// tb_addsub_sequencer: directed plus random requests against two instances
// (unprotected and PROTECT_R0=1), each with its own register file.
module tb_addsub_sequencer;
    logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_op = 1'b0;
    logic [3:0]  req_rs_a = '0, req_rs_b = '0, req_rd = '0;
    logic        ready0, wr0, done0, c0, v0, z0;
    logic        ready1, wr1, done1, c1, v1, z1;
    logic [3:0]  sa0, sb0, dr0, sa1, sb1, dr1;
    logic [15:0] wd0, res0, wd1, res1;
    logic [15:0] rf0 [16];
    logic [15:0] rf1 [16];
    logic [15:0] m0 [16];
    logic [15:0] m1 [16];
    logic        bw_en = 1'b0;
    logic [3:0]  bw_a = '0;
    logic [15:0] bw_d = '0;
    int          cyc = 0, npass = 0, ntot = 0, last_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (wr0) rf0[dr0] <= wd0;
        if (wr1) rf1[dr1] <= wd1;
        if (bw_en) begin
            rf0[bw_a] <= bw_d;
            rf1[bw_a] <= bw_d;
        end
    end

    addsub_sequencer #(.DATA_W(16), .ADDR_W(4), .PROTECT_R0(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
        .req_op(req_op), .req_rs_a(req_rs_a), .req_rs_b(req_rs_b), .req_rd(req_rd),
        .srcRegA(sa0), .srcRegB(sb0), .outBusA(rf0[sa0]), .outBusB(rf0[sb0]),
        .regWrite(wr0), .destReg(dr0), .writeData(wd0), .done(done0),
        .result(res0), .flag_c(c0), .flag_v(v0), .flag_z(z0));

    addsub_sequencer #(.DATA_W(16), .ADDR_W(4), .PROTECT_R0(1'b1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
        .req_op(req_op), .req_rs_a(req_rs_a), .req_rs_b(req_rs_b), .req_rd(req_rd),
        .srcRegA(sa1), .srcRegB(sb1), .outBusA(rf1[sa1]), .outBusB(rf1[sb1]),
        .regWrite(wr1), .destReg(dr1), .writeData(wd1), .done(done1),
        .result(res1), .flag_c(c1), .flag_v(v1), .flag_z(z1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic, signed range check for overflow.
    task automatic ref_op(input bit op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic c, output logic v, output logic z);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = op ? sa - sb : sa + sb;
        r  = op ? a - b : a + b;
        c  = op ? (a >= b) : ((int'(a) + int'(b)) > 65535);
        v  = (s > 32767) || (s < -32768);
        z  = (r == 16'h0);
    endtask

    task automatic poke(input logic [3:0] a, input logic [15:0] d);
        bw_en = 1'b1; bw_a = a; bw_d = d;
        @(negedge clk);
        bw_en = 1'b0;
        m0[a] = d;
        m1[a] = d;
    endtask

    task automatic run(input bit op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rd, input bit hold);
        logic [15:0] er0, er1;
        logic        ec, ev, ez, ec1, ev1, ez1;
        ref_op(op, m0[ra], m0[rb], er0, ec, ev, ez);
        ref_op(op, m1[ra], m1[rb], er1, ec1, ev1, ez1);
        req_op = op; req_rs_a = ra; req_rs_b = rb; req_rd = rd; req_valid = 1'b1;
        chk("ready_idle", ready0, 1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        chk("ready_read", ready0, 0);
        chk("srcA", sa0, ra);
        chk("srcB", sb0, rb);
        chk("done_read", done0, 0);
        @(negedge clk);
        chk("done_exec", done0, 0);
        chk("wr_exec", wr0, 0);
        @(negedge clk);
        chk("done_write", done0, 1);
        chk("wr_write", wr0, 1);
        chk("destReg", dr0, rd);
        chk("writeData", wd0, er0);
        chk("result", res0, er0);
        chk("flags_cvz", {c0, v0, z0}, {ec, ev, ez});
        chk("p_done", done1, 1);
        chk("p_wr", wr1, rd != 4'd0);
        chk("p_result", res1, er1);
        chk("p_flags", {c1, v1, z1}, {ec1, ev1, ez1});
        last_done = cyc;
        m0[rd] = er0;
        if (rd != 4'd0) m1[rd] = er1;
        @(negedge clk);
        if (hold) req_valid = 1'b0;
        chk("ready_back", ready0, 1);
        chk("done_after", done0, 0);
        chk("result_held", res0, er0);
        chk("rf_commit", rf0[rd], m0[rd]);
        chk("p_rf_commit", rf1[rd], m1[rd]);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {wr0, done0, c0, v0, z0, sa0, sb0, dr0, wd0, res0}, '0);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 16; i++) begin m0[i] = '0; m1[i] = '0; end
        repeat (2) @(negedge clk);
        chk_zero("in_reset");
        reset = 1'b1;
        @(negedge clk);
        chk_zero("after_reset");
        chk("ready_reset", ready0, 1);
        for (int i = 0; i < 16; i++) poke(4'(i), 16'(i));
        poke(4'd10, 16'h7FFF);
        poke(4'd12, 16'h8000);
        poke(4'd13, 16'hFFFF);
        run(1'b0, 4'd2, 4'd4, 4'd6, 1'b0);
        chk("r6_is_6", rf0[6], 16'd6);
        run(1'b1, 4'd8, 4'd2, 4'd3, 1'b0);
        chk("sub_pos", wd0, 16'h0006);
        run(1'b1, 4'd2, 4'd8, 4'd3, 1'b0);
        chk("sub_neg", {wd0, c0, v0}, {16'hFFFA, 2'b00});
        run(1'b0, 4'd10, 4'd1, 4'd5, 1'b0);
        chk("ovf_add", {wd0, v0, c0}, {16'h8000, 2'b10});
        run(1'b1, 4'd12, 4'd1, 4'd5, 1'b0);
        chk("ovf_sub", {wd0, v0, c0}, {16'h7FFF, 2'b11});
        run(1'b0, 4'd13, 4'd1, 4'd5, 1'b0);
        chk("wrap", {wd0, z0, c0, v0}, {16'h0000, 3'b110});
        run(1'b0, 4'd2, 4'd4, 4'd1, 1'b1);
        t = last_done;
        run(1'b0, 4'd1, 4'd1, 4'd1, 1'b1);
        chk("dep_12", wd0, 16'd12);
        chk("done_spacing", last_done - t, 4);
        repeat (4) begin
            @(negedge clk);
            chk("no_extra_done", done0, 0);
        end
        // Abort during EXEC: no write must ever reach r9.
        req_op = 1'b0; req_rs_a = 4'd2; req_rs_b = 4'd4; req_rd = 4'd9; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero("abort_exec_zero");
        repeat (3) begin
            @(negedge clk);
            chk("abort_exec_quiet", {wr0, done0}, 2'b00);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_exec_r9", rf0[9], m0[9]);
        // Abort during WRITE: regWrite must drop without a clock edge.
        req_rd = 4'd9; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_wr_pre", wr0, 1);
        reset = 1'b0;
        #1;
        chk("abort_wr_drop", {wr0, done0}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_wr_r9", rf0[9], m0[9]);
        run(1'b0, 4'd2, 4'd4, 4'd9, 1'b0);
        poke(4'd5, 16'd5);
        poke(4'd3, 16'd3);
        run(1'b0, 4'd5, 4'd3, 4'd0, 1'b0);
        chk("p_r0_result", res1, 16'd8);
        chk("p_r0_kept", rf1[0], 16'd0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) poke(4'($urandom), 16'($urandom));
            run(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/addsub_sequencer.md
Name: addsub_sequencer

Overview:
- Initiator side of the 16-entry x 16-bit register-file port: the block that drives srcRegA, srcRegB, destReg, writeData and regWrite, and consumes outBusA and outBusB.
- Accepts one add/subtract request at a time over a valid/ready handshake.
- For each request: reads two source registers, computes A+B or A-B, writes the result back to the destination register, then reports done and status flags.
- Sits between the instruction-decode logic and registerFile in the addsub datapath.

Parameters:
- DATA_W, 16, register and datapath width.
- ADDR_W, 4, register index width (2**ADDR_W registers).
- PROTECT_R0, 0, when 1, writes to register 0 are suppressed (done and flags are still produced).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_op  input  1  0 = add (A+B), 1 = subtract (A-B).
- req_rs_a  input  ADDR_W  source register A index.
- req_rs_b  input  ADDR_W  source register B index.
- req_rd  input  ADDR_W  destination register index.
- srcRegA  output  ADDR_W  register-file read address A.
- srcRegB  output  ADDR_W  register-file read address B.
- outBusA  input  DATA_W  register-file read data A (combinational from srcRegA).
- outBusB  input  DATA_W  register-file read data B (combinational from srcRegB).
- regWrite  output  1  register-file write enable.
- destReg  output  ADDR_W  register-file write address.
- writeData  output  DATA_W  register-file write data.
- done  output  1  one-cycle pulse: operation complete.
- result  output  DATA_W  last result; held until the next done.
- flag_c  output  1  carry out (for subtract: 1 = no borrow).
- flag_v  output  1  signed overflow.
- flag_z  output  1  result == 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - regWrite, done, flags, srcRegA/B, destReg, writeData and result are all 0.
  - The internal request latch is cleared.
  - Assertion mid-operation aborts the operation: no write is issued afterwards, and regWrite drops immediately without waiting for a clock edge.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE. The block never stalls inside an operation.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, the request is accepted: req_op, req_rs_a, req_rs_b and req_rd are latched, srcRegA/srcRegB are registered with the source indices, and the FSM moves to READ.
  - Request inputs outside IDLE are ignored; the requester must hold them until acceptance.
- READ:
  - srcRegA/B are stable.
  - At the end of the cycle, outBusA and outBusB are captured into opA and opB. Go to EXEC.
- EXEC:
  - Sum = opA + (op ? ~opB : opB) + op, computed DATA_W+1 bits wide.
  - Result = sum[DATA_W-1:0]; C = sum[DATA_W].
  - V = (opA[msb] == (op ? ~opB[msb] : opB[msb])) && (result[msb] != opA[msb]).
  - Z = (result == 0).
  - Registered into destReg/writeData together with pending flags. Go to WRITE.
- WRITE:
  - regWrite=1 for exactly this one cycle, so the register file stores the value on the WRITE->IDLE edge.
  - If PROTECT_R0=1 and rd=0, regWrite stays 0.
  - done=1 in this same cycle; result and flags are valid from this cycle and held until the next WRITE.
- Latency: accept edge at cycle k; READ at k+1; EXEC at k+2; WRITE/done at k+3. req_ready returns at k+4.
- Throughput: one operation per 4 cycles.
- srcRegA/B and destReg/writeData hold their last values outside their active states. regWrite is the only write qualifier.
- Back-to-back dependency: a new request may read the register written by the previous operation. This is safe because that write commits before the next READ.
- Wrap-around: arithmetic is modulo 2**DATA_W. Examples: 0xFFFF+0x0001 gives 0x0000, C=1, Z=1, V=0. 0x0000-0x0001 gives 0xFFFF, C=0, V=0.
- rs_a == rs_b == rd is legal; the operands are read before the write.

Test Plan:
- Reset low for 2 cycles, then release: all outputs 0 and req_ready=1. Then add rs_a=2 (holding 2) and rs_b=4 (holding 4) into rd=6 -> regWrite pulse at k+3 with destReg=6 and writeData=6; done=1; C=0, V=0, Z=0; the register file later reads 6 from r6.
- Subtract r8 (0x0008) minus r2 (0x0002) into r3 -> writeData=0x0006, C=1, Z=0. Then r2 minus r8 into r3 -> 0xFFFA, C=0, V=0.
- Overflow corners:
  - 0x7FFF+0x0001 -> 0x8000, V=1, C=0.
  - 0x8000-0x0001 -> 0x7FFF, V=1, C=1.
  - 0xFFFF+0x0001 -> 0x0000, Z=1, C=1.
- Dependent requests, each issued as soon as req_ready rises:
  - r1 = r2+r4 = 6, then r1 = r1+r1 -> writeData=12.
  - Spacing between done pulses is exactly 4 cycles.
  - req_valid held high outside IDLE causes no extra operations.
- Reset asserted during EXEC -> regWrite never asserts, done never pulses, and the target register is unchanged. After release, a fresh request completes normally.
- PROTECT_R0=1 with rd=0 and 5+3 -> done=1 and result=8, but regWrite stays 0 and r0 is unchanged.
